shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle 32-bit barrel-shift controller. One request (data, direction, amount)
//  is resolved by applying one power-of-two shift stage (16,8,4,2,1) per clock to an
//  internal working register. Sits between the ALU issue logic and the writeback mux.
//  Trades the full combinational shifter for 5 cycles of latency.
//  Uses valid/ready handshakes on both the request side and the result side.
// PARAMETERS
//  WIDTH   32  data width; must be a power of two
//  AMT_W   5   shift-amount width; equals log2(WIDTH); also the number of stages
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  RST        in   1      synchronous, active-high reset
//  IN_VALID   in   1      request present
//  IN_READY   out  1      block can accept a request (high only in IDLE)
//  SH_DIR     in   1      1 = shift right arithmetic, 0 = shift left logical
//  SH_AMT     in   AMT_W  shift amount, 0..WIDTH-1
//  D_IN       in   WIDTH  operand
//  OUT_VALID  out  1      result valid (high only in DONE)
//  OUT_READY  in   1      consumer accepts result
//  D_OUT      out  WIDTH  result, registered
//  BUSY       out  1      high in SHIFT or DONE
// BEHAVIOUR
//  Reset (RST=1 at an edge): state=IDLE, D_OUT=0, OUT_VALID=0, BUSY=0, stage cnt=0.
//   IN_READY=1 from the first cycle after RST is deasserted. Reset overrides every
//   other input and aborts any request in flight; the partial result is discarded.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: IN_READY=1. On an edge with IN_VALID=1, latch D_IN into the working register.
//   Also latch SH_AMT and SH_DIR, set cnt=AMT_W-1, and go to SHIFT.
//  SHIFT: on each edge, if amt[cnt]=1, shift the working register by 2^cnt; else hold it.
//   Right shift: upper 2^cnt bits are filled with the sign bit (bit WIDTH-1).
//   Left shift: lower 2^cnt bits are filled with 0.
//   If cnt=0, go to DONE; else cnt<=cnt-1.
//  Stage order is always 16,8,4,2,1. Every stage is visited even when its amount bit
//   is 0. Latency is therefore fixed: OUT_VALID rises exactly AMT_W edges after the
//   accept edge, independent of SH_AMT.
//  DONE: OUT_VALID=1. D_OUT equals the working register and is held stable.
//   On an edge with OUT_READY=1, go to IDLE and drop OUT_VALID.
//   D_OUT keeps its last value in IDLE. The next request cannot be accepted before the
//   cycle after the result handshake (no overlap).
//  In SHIFT and DONE, IN_READY=0 and IN_VALID is ignored. Inputs sampled at the accept
//   edge are the only ones used; later changes on D_IN/SH_AMT/SH_DIR have no effect.
//  Width rule: the result equals the single-cycle shifter: {D>>>AMT} or {D<<AMT},
//   truncated to WIDTH.
// TESTING
//  T1 reset: hold RST 2 cycles mid-idle. Required: D_OUT=0, OUT_VALID=0, BUSY=0,
//     and IN_READY=1 the cycle after release.
//  T2 left: D_IN=0x000000FF, SH_DIR=0, SH_AMT=8. Required: D_OUT=0x0000FF00 with
//     OUT_VALID rising exactly 5 edges after accept; BUSY high throughout.
//  T3 arithmetic right: D_IN=0x80000000, SH_DIR=1, SH_AMT=31 gives 0xFFFFFFFF.
//     D_IN=0x40000000, SH_DIR=1, SH_AMT=31 gives 0x00000000.
//     D_IN=0xF0F0F0F0, SH_DIR=1, SH_AMT=13 gives 0xFFFF8787.
//  T4 zero amount: D_IN=0x12345678, SH_AMT=0, either direction. Required: D_OUT=0x12345678
//     after the same 5-edge latency.
//  T5 backpressure: hold OUT_READY=0 for 3 cycles in DONE and drive a new request.
//     Required: D_OUT/OUT_VALID stable, IN_READY=0, new request not taken.
//     Then raise OUT_READY: IDLE next cycle, and the new request is accepted the
//     following edge.
//  T6 reset mid-op: assert RST on the 3rd SHIFT edge. Required: IDLE with reset
//     outputs the next cycle. A following D_IN=0x00000001, SH_DIR=0, SH_AMT=31
//     then yields 0x80000000.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle barrel shifter. A request is latched in IDLE, then one
// power-of-two stage (largest first) is applied per clock in SHIFT. The registered
// result is presented in DONE until the consumer accepts it.
module shift_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             SH_DIR,
  input  logic [AMT_W-1:0] SH_AMT,
  input  logic [WIDTH-1:0] D_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D_OUT,
  output logic             BUSY
);

  localparam int unsigned CNT_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(AMT_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [AMT_W-1:0]   amt_q;
  logic               dir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   stage_d;

  // Working register after the current stage: shift by 2^cnt if that amount bit is set.
  always_comb begin
    stage_d = work_q;
    for (int unsigned i = 0; i < AMT_W; i++) begin
      if (cnt_q == CNT_W'(i) && amt_q[i]) begin
        if (dir_q) begin
          stage_d = $signed(work_q) >>> (1 << i);
        end else begin
          stage_d = work_q << (1 << i);
        end
      end
    end
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      work_q    <= '0;
      amt_q     <= '0;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      D_OUT     <= '0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (IN_VALID) begin
            work_q   <= D_IN;
            amt_q    <= SH_AMT;
            dir_q    <= SH_DIR;
            cnt_q    <= LAST_STAGE;
            state_q  <= StShift;
            IN_READY <= 1'b0;
            BUSY     <= 1'b1;
          end
        end
        StShift: begin
          work_q <= stage_d;
          if (cnt_q == '0) begin
            // Final stage: publish the result in the same edge.
            state_q   <= StDone;
            D_OUT     <= stage_d;
            OUT_VALID <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StDone: begin
          if (OUT_READY) begin
            state_q   <= StIdle;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            IN_READY  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          OUT_VALID <= 1'b0;
          BUSY      <= 1'b0;
          IN_READY  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized requests
// compared against a one-shot shift reference.
module tb_shift_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AMT_W = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             sh_dir;
  logic [AMT_W-1:0] sh_amt;
  logic [WIDTH-1:0] d_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d_out;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  shift_sequencer #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .SH_DIR    (sh_dir),
    .SH_AMT    (sh_amt),
    .D_IN      (d_in),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .D_OUT     (d_out),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: the single-cycle shifter result.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic dir,
                                            input int amt);
    if (dir) return $signed(d) >>> amt;
    return d << amt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, then follow the fixed 5-edge latency to DONE.
  task automatic accept_and_shift(input logic [31:0] d, input logic dir, input int amt);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    d_in     = d;
    sh_dir   = dir;
    sh_amt   = AMT_W'(amt);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Later input changes must not matter.
    d_in     = $urandom;
    sh_dir   = 1'($urandom);
    sh_amt   = AMT_W'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    for (int k = 1; k <= int'(AMT_W); k++) begin
      check("out_valid_before_latency", 32'(out_valid), 32'd0);
      tick();
      check("busy_in_shift", 32'(busy), 32'd1);
    end
    check("out_valid_at_latency", 32'(out_valid), 32'd1);
    check("d_out_result", d_out, ref_shift(d, dir, amt));
  endtask

  // Accept the result after 'stall' cycles of backpressure.
  task automatic collect(input logic [31:0] exp, input int stall);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_d_out", d_out, exp);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_d_out_held", d_out, exp);
  endtask

  task automatic run_op(input logic [31:0] d, input logic dir, input int amt, input int stall);
    accept_and_shift(d, dir, amt);
    collect(ref_shift(d, dir, amt), stall);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rdir;
    int          ramt;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sh_dir    = 1'b0;
    sh_amt    = '0;
    d_in      = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_d_out", d_out, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // T2 left shift
    run_op(32'h0000_00FF, 1'b0, 8, 0);
    check("t2_value", d_out, 32'h0000_FF00);

    // T1 reset mid-idle with a nonzero held result
    rst = 1'b1;
    tick();
    check("t1_in_reset_d_out", d_out, 32'd0);
    tick();
    rst = 1'b0;
    check("t1_d_out", d_out, 32'd0);
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    tick();
    check("t1_in_ready", 32'(in_ready), 32'd1);

    // T3 arithmetic right
    run_op(32'h8000_0000, 1'b1, 31, 0);
    check("t3a_value", d_out, 32'hFFFF_FFFF);
    run_op(32'h4000_0000, 1'b1, 31, 1);
    check("t3b_value", d_out, 32'h0000_0000);
    run_op(32'hF0F0_F0F0, 1'b1, 13, 0);
    check("t3c_value", d_out, 32'hFFFF_8787);

    // T4 zero amount, both directions
    run_op(32'h1234_5678, 1'b0, 0, 0);
    check("t4l_value", d_out, 32'h1234_5678);
    run_op(32'h1234_5678, 1'b1, 0, 0);
    check("t4r_value", d_out, 32'h1234_5678);

    // T5 backpressure with a competing request held on the input
    accept_and_shift(32'hDEAD_BEEF, 1'b0, 4);
    d_in     = 32'h0000_0003;
    sh_dir   = 1'b0;
    sh_amt   = AMT_W'(1);
    in_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("t5_out_valid", 32'(out_valid), 32'd1);
      check("t5_d_out", d_out, 32'hEADB_EEF0);
      check("t5_in_ready", 32'(in_ready), 32'd0);
      check("t5_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_idle_out_valid", 32'(out_valid), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    run_op(32'h0000_0003, 1'b0, 1, 0);
    check("t5_new_value", d_out, 32'h0000_0006);

    // T6 reset on the 3rd SHIFT edge
    d_in     = 32'hFFFF_0000;
    sh_dir   = 1'b1;
    sh_amt   = AMT_W'(7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_state_in_ready", 32'(in_ready), 32'd1);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_d_out", d_out, 32'd0);
    for (int s = 0; s < 6; s++) begin
      tick();
      check("t6_no_stale_valid", 32'(out_valid), 32'd0);
    end
    run_op(32'h0000_0001, 1'b0, 31, 0);
    check("t6_after_value", d_out, 32'h8000_0000);

    // Randomized requests with random backpressure
    for (int n = 0; n < 60; n++) begin
      rd   = $urandom;
      rdir = 1'($urandom);
      ramt = int'($urandom_range(0, WIDTH - 1));
      if (n % 4 == 0) rd[31] = 1'b1;
      run_op(rd, rdir, ramt, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
